seq_pattern_detector: RTL and testbench

Parametrised serial pattern detector, the successor to the fixed "1011" detector FSM. It replaces the hard-coded state machine with a runtime-loadable pattern of 1..PAT_W bits and selectable overlapping or non-overlapping match mode. It also adds a saturating match counter and a configuration-error flag. It sits on the same qualified serial bit stream (data_in/data_valid) and produces a registered one-cycle match pulse plus progress and status outputs.

---
 rtl/seq_pattern_detector.sv | 113 +++++++++++
 tb/tb_seq_pattern_detector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a runtime-loadable pattern of 1..PAT_W bits,
// overlapping/non-overlapping match modes and a saturating match counter.
module seq_pattern_detector #(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [PAT_W-1:0] RST_PATTERN = 8'b0000_1011,
  parameter int               RST_LEN     = 4,
  parameter bit               RST_OVERLAP = 1'b1,
  localparam int              LW          = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [LW-1:0]    len_in,
  input  logic             overlap_in,
  input  logic             count_clr,
  output logic             data_out,
  output logic [LW-1:0]    state_out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic             cfg_err
);

  localparam logic [LW-1:0]    FULL    = LW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist_n;
  logic [PAT_W-1:0] len_mask;
  logic [LW-1:0]    fill;
  logic [LW-1:0]    len;
  logic [LW-1:0]    fill_n;
  logic [LW-1:0]    fill_upd;
  logic             ovl;
  logic             match;
  logic             cfg_err_c;
  logic [CNT_W:0]   cnt_inc;

  function automatic logic [LW-1:0] min_lw(input logic [LW-1:0] a, input logic [LW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Returns {reached_all_ones, next_count}; holds at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] n;
    n = (&c) ? c : c + CNT_ONE;
    return {&n, n};
  endfunction

  assign cfg_err_c = (len == '0) || (len > FULL);
  assign cfg_err   = cfg_err_c;

  always_comb begin
    hist_n   = {hist[PAT_W-2:0], data_in};
    fill_n   = (fill >= FULL) ? FULL : fill + LW'(1);
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len));
    end
    match    = data_valid && !cfg_load && !cfg_err_c && (fill_n >= len) &&
               (((hist_n ^ pat) & len_mask) == '0);
    // Non-overlap mode restarts the window so no matched bit is reused.
    fill_upd = (match && !ovl) ? '0 : fill_n;
    cnt_inc  = sat_inc(match_count);
  end

  // Stage p0: history, configuration and match pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= RST_PATTERN;
      len       <= LW'(RST_LEN);
      ovl       <= RST_OVERLAP;
      data_out  <= 1'b0;
      state_out <= '0;
    end else if (cfg_load) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= pattern_in;
      len       <= len_in;
      ovl       <= overlap_in;
      data_out  <= 1'b0;
      state_out <= '0;
    end else if (data_valid) begin
      hist      <= hist_n;
      fill      <= fill_upd;
      data_out  <= match;
      state_out <= cfg_err_c ? '0 : min_lw(fill_upd, len);
    end else begin
      data_out  <= 1'b0;
    end
  end

  // Stage p0: saturating match counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (count_clr) begin
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (match) begin
      match_count <= cnt_inc[CNT_W-1:0];
      count_sat   <= count_sat | cnt_inc[CNT_W];
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_seq_pattern_detector;

  localparam int PAT_W = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        data_in, data_valid, cfg_load, overlap_in, count_clr;
  logic [7:0]  pattern_in;
  logic [3:0]  len_in;
  logic        data_out, count_sat, cfg_err;
  logic [3:0]  state_out;
  logic [15:0] match_count;
  logic        s_data_out, s_count_sat, s_cfg_err;
  logic [3:0]  s_state_out;
  logic [1:0]  s_match_count;

  int checks = 0;
  int errors = 0;

  seq_pattern_detector dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .pattern_in(pattern_in), .len_in(len_in),
    .overlap_in(overlap_in), .count_clr(count_clr), .data_out(data_out),
    .state_out(state_out), .match_count(match_count), .count_sat(count_sat),
    .cfg_err(cfg_err)
  );

  seq_pattern_detector #(.CNT_W(2)) dut_small (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .cfg_load(cfg_load), .pattern_in(pattern_in), .len_in(len_in),
    .overlap_in(overlap_in), .count_clr(count_clr), .data_out(s_data_out),
    .state_out(s_state_out), .match_count(s_match_count), .count_sat(s_count_sat),
    .cfg_err(s_cfg_err)
  );

  always #5 clk = ~clk;

  // Reference model: the window is the list of bits received since the last
  // clear, capped at PAT_W; a match compares its tail with the pattern.
  bit         win[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         m_cnt, m_cnt2;
  bit         m_sat, m_sat2;
  bit         e_out, e_err;
  int         e_state;

  function automatic bit m_bad();
    return (m_len == 0) || (m_len > PAT_W);
  endfunction

  function automatic void model_reset();
    win.delete();
    m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
    m_cnt = 0; m_cnt2 = 0; m_sat = 0; m_sat2 = 0;
    e_out = 0; e_err = 0; e_state = 0;
  endfunction

  function automatic void model_step();
    bit hit;
    hit = 0;
    e_out = 0;
    if (cfg_load) begin
      m_pat = pattern_in; m_len = int'(len_in); m_ovl = overlap_in;
      win.delete();
    end else if (data_valid) begin
      win.push_back(data_in);
      if (win.size() > PAT_W) void'(win.pop_front());
      if (!m_bad() && win.size() >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++)
          if (win[win.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
      end
      if (hit) begin
        e_out = 1;
        if (!m_ovl) win.delete();
      end
    end
    if (count_clr) begin
      m_cnt = 0; m_sat = 0; m_cnt2 = 0; m_sat2 = 0;
    end else if (hit) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt == 65535) m_sat = 1;
      if (m_cnt2 < 3) m_cnt2++;
      if (m_cnt2 == 3) m_sat2 = 1;
    end
    e_err   = m_bad();
    e_state = e_err ? 0 : ((win.size() < m_len) ? win.size() : m_len);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("data_out", 32'(data_out), 32'(e_out));
    check("state_out", 32'(state_out), 32'(e_state));
    check("match_count", 32'(match_count), 32'(m_cnt));
    check("count_sat", 32'(count_sat), 32'(m_sat));
    check("cfg_err", 32'(cfg_err), 32'(e_err));
    check("small_count", 32'(s_match_count), 32'(m_cnt2));
    check("small_sat", 32'(s_count_sat), 32'(m_sat2));
  endtask

  task automatic step(input logic ld, input logic [7:0] p, input logic [3:0] l,
                      input logic o, input logic dv, input logic d, input logic clr);
    cfg_load = ld; pattern_in = p; len_in = l; overlap_in = o;
    data_valid = dv; data_in = d; count_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic bitc(input logic dv, input logic d);
    step(1'b0, 8'h00, 4'd0, 1'b0, dv, d, 1'b0);
  endtask

  task automatic async_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check("arst_data_out", 32'(data_out), 0);
    check("arst_state_out", 32'(state_out), 0);
    check("arst_count", 32'(match_count), 0);
    check("arst_sat", 32'(count_sat), 0);
    check("arst_cfg_err", 32'(cfg_err), 0);
    check("arst_small_count", 32'(s_match_count), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic        ld;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic        dv;
    logic        din;
    logic        clr;
    logic        e_out;
    logic [3:0]  e_state;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic tbit(input logic dv, input logic d, input logic eo, input logic [3:0] es,
                      input logic [15:0] ec, input logic ee);
    vec_t v;
    v = '{1'b0, 8'h00, 4'd0, 1'b0, dv, d, 1'b0, eo, es, ec, ee};
    tbl.push_back(v);
  endtask

  task automatic tcfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic dv,
                      input logic d, input logic clr, input logic [15:0] ec, input logic ee);
    vec_t v;
    v = '{1'b1, p, l, o, dv, d, clr, 1'b0, 4'd0, ec, ee};
    tbl.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0; data_in = 0; data_valid = 0; cfg_load = 0;
    pattern_in = '0; len_in = '0; overlap_in = 0; count_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 0);
    check("rst_state_out", 32'(state_out), 0);
    check("rst_count", 32'(match_count), 0);
    check("rst_sat", 32'(count_sat), 0);
    check("rst_cfg_err", 32'(cfg_err), 0);
    reset_n = 1'b1;

    // Default 1011 overlap; then non-overlap; then 11 with gaps; then bad lengths.
    tbit(1,1,0,1,0,0); tbit(1,0,0,2,0,0); tbit(1,1,0,3,0,0); tbit(1,1,1,4,1,0);
    tbit(1,0,0,4,1,0); tbit(1,1,0,4,1,0); tbit(1,1,1,4,2,0);
    tcfg(8'h0B,4,0,1,1,1,0,0);
    tbit(1,1,0,1,0,0); tbit(1,0,0,2,0,0); tbit(1,1,0,3,0,0); tbit(1,1,1,0,1,0);
    tbit(1,0,0,1,1,0); tbit(1,1,0,2,1,0); tbit(1,1,0,3,1,0);
    tcfg(8'h03,2,1,0,0,0,1,0);
    tbit(1,1,0,1,1,0); tbit(0,0,0,1,1,0); tbit(1,1,1,2,2,0); tbit(0,1,0,2,2,0);
    tbit(1,1,1,2,3,0); tbit(0,0,0,2,3,0); tbit(1,1,1,2,4,0);
    tcfg(8'h03,0,1,0,0,0,4,1);
    tbit(1,1,0,0,4,1); tbit(1,1,0,0,4,1); tbit(1,1,0,0,4,1);
    tcfg(8'hFF,9,1,0,0,0,4,1);
    tbit(1,1,0,0,4,1); tbit(1,1,0,0,4,1); tbit(1,1,0,0,4,1);
    tcfg(8'hF5,3,1,0,0,0,4,0);
    tbit(1,1,0,1,4,0); tbit(1,0,0,2,4,0); tbit(1,1,1,3,5,0);

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].pat, tbl[i].len, tbl[i].ovl, tbl[i].dv, tbl[i].din, tbl[i].clr);
      check($sformatf("vec%0d_out", i), 32'(data_out), 32'(tbl[i].e_out));
      check($sformatf("vec%0d_state", i), 32'(state_out), 32'(tbl[i].e_state));
      check($sformatf("vec%0d_count", i), 32'(match_count), 32'(tbl[i].e_cnt));
      check($sformatf("vec%0d_err", i), 32'(cfg_err), 32'(tbl[i].e_err));
    end

    // Counter saturation on the 2-bit instance, then clear racing a match.
    step(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    bitc(1, 1); bitc(1, 1);
    check("sat_cnt_2", 32'(s_match_count), 2);
    check("sat_flag_2", 32'(s_count_sat), 0);
    bitc(1, 1);
    check("sat_cnt_3", 32'(s_match_count), 3);
    check("sat_flag_3", 32'(s_count_sat), 1);
    step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_pulse", 32'(s_data_out), 1);
    check("clr_cnt", 32'(s_match_count), 0);
    check("clr_flag", 32'(s_count_sat), 0);
    bitc(1, 1);
    check("after_clr_cnt", 32'(s_match_count), 1);

    // Reset in the middle of a partial match.
    step(1'b1, 8'h0B, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    bitc(1, 1); bitc(1, 0); bitc(1, 1);
    check("pre_rst_state", 32'(state_out), 3);
    async_reset();
    bitc(1, 1);
    check("post_rst_nomatch", 32'(data_out), 0);
    bitc(1, 1); bitc(1, 0); bitc(1, 1); bitc(1, 1);
    check("post_rst_match", 32'(data_out), 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic ld, clr;
      logic [3:0] l;
      ld  = ($urandom_range(0, 99) < 3);
      clr = ($urandom_range(0, 99) < 2);
      l   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      if ($urandom_range(0, 999) < 2) async_reset();
      step(ld, 8'($urandom), l, 1'($urandom), ($urandom_range(0, 9) < 7), 1'($urandom), clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
